// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of a five-stage RV32I pipeline. It sends load/store
// requests to the data cache, waits for the load response, builds store byte
// masks with replicated store data, flags misaligned accesses, and owns the
// MEM/WB pipeline register.
//
// Handshake rules (valid/ready):
//   * A request transfers in a cycle where dcache_req_valid and dcache_req_ready
//     are both high. While valid is high and ready is low, the request and all
//     *_MEM inputs stay stable. The stall keeps upstream from changing them.
//   * dcache_resp_valid is a single-cycle strobe. There is no back-pressure on
//     the response. A response that arrives while no load is outstanding is
//     ignored.
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   valid_MEM, flush_MEM           instruction present / kill it
//   inst_MEM, pc_MEM, ALU_MEM      instruction, PC, effective address
//   rs2_MEM, WB_sel_MEM            store data, write-back select
//   stall_MEM                      instruction cannot leave MEM this cycle
//   dcache_req_*, dcache_addr/we/din   request channel to the data cache
//   dcache_resp_valid/data         load response
//   *_WB, dcache_dout_WB, misalign_WB  registered MEM/WB fields
//   state_dbg                      FSM state (0 IDLE, 1 WAIT_RESP, 2 DRAIN)
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_MEM,
  input  logic              flush_MEM,
  input  logic [INST_W-1:0] inst_MEM,
  input  logic [ADDR_W-1:0] pc_MEM,
  input  logic [DATA_W-1:0] ALU_MEM,
  input  logic [DATA_W-1:0] rs2_MEM,
  input  logic [1:0]        WB_sel_MEM,
  output logic              stall_MEM,
  output logic              dcache_req_valid,
  input  logic              dcache_req_ready,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic [3:0]        dcache_we,
  output logic [DATA_W-1:0] dcache_din,
  input  logic              dcache_resp_valid,
  input  logic [DATA_W-1:0] dcache_resp_data,
  output logic              valid_WB,
  output logic [INST_W-1:0] inst_WB,
  output logic [ADDR_W-1:0] pc_WB,
  output logic [DATA_W-1:0] ALU_WB,
  output logic [1:0]        WB_sel_WB,
  output logic [DATA_W-1:0] dcache_dout_WB,
  output logic              misalign_WB,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    DRAIN     = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  state_e              state_q, state_d;
  logic                valid_wb_q, valid_wb_d;
  logic [INST_W-1:0]   inst_wb_q, inst_wb_d;
  logic [ADDR_W-1:0]   pc_wb_q, pc_wb_d;
  logic [DATA_W-1:0]   alu_wb_q, alu_wb_d;
  logic [1:0]          wb_sel_wb_q, wb_sel_wb_d;
  logic [DATA_W-1:0]   dout_wb_q, dout_wb_d;
  logic                misalign_wb_q, misalign_wb_d;

  logic       is_load, is_store, is_mem, misaligned, mem_go;
  logic [1:0] size_sel;

  assign is_load  = (inst_MEM[6:0] == OPC_LOAD);
  assign is_store = (inst_MEM[6:0] == OPC_STORE);
  assign is_mem   = is_load | is_store;
  assign size_sel = inst_MEM[13:12];

  assign misaligned = ((size_sel == 2'b01) & ALU_MEM[0]) |
                      ((size_sel == 2'b10) & (ALU_MEM[1:0] != 2'b00));

  // An aligned, unflushed memory op is the only thing that talks to the cache.
  assign mem_go = valid_MEM & ~flush_MEM & is_mem & ~misaligned;

  assign dcache_addr = {ALU_MEM[ADDR_W-1:2], 2'b00};

  // Store byte lanes and lane-replicated data.
  always_comb begin
    dcache_we  = 4'b0000;
    dcache_din = rs2_MEM;
    case (size_sel)
      2'b00: begin
        dcache_we  = 4'b0001 << ALU_MEM[1:0];
        dcache_din = {4{rs2_MEM[7:0]}};
      end
      2'b01: begin
        dcache_we  = ALU_MEM[1] ? 4'b1100 : 4'b0011;
        dcache_din = {2{rs2_MEM[15:0]}};
      end
      default: begin
        dcache_we  = 4'b1111;
        dcache_din = rs2_MEM;
      end
    endcase
    if (!is_store) dcache_we = 4'b0000;
  end

  // Next state, request/stall generation and MEM/WB register update.
  always_comb begin
    state_d          = state_q;
    dcache_req_valid = 1'b0;
    stall_MEM        = 1'b0;
    valid_wb_d       = valid_wb_q;
    inst_wb_d        = inst_wb_q;
    pc_wb_d          = pc_wb_q;
    alu_wb_d         = alu_wb_q;
    wb_sel_wb_d      = wb_sel_wb_q;
    dout_wb_d        = dout_wb_q;
    misalign_wb_d    = misalign_wb_q;

    case (state_q)
      IDLE: begin
        if (mem_go) begin
          dcache_req_valid = 1'b1;
          // Only an accepted store leaves at once; an accepted load waits.
          stall_MEM = ~(is_store & dcache_req_ready);
          if (is_load && dcache_req_ready) state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (dcache_resp_valid) begin
          state_d = IDLE;
        end else begin
          stall_MEM = 1'b1;
          if (flush_MEM) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The killed load's response must be swallowed before the next op.
        stall_MEM = 1'b1;
        if (dcache_resp_valid) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (stall_MEM) begin
      valid_wb_d = 1'b0;
    end else begin
      valid_wb_d    = valid_MEM & ~flush_MEM;
      inst_wb_d     = inst_MEM;
      pc_wb_d       = pc_MEM;
      alu_wb_d      = ALU_MEM;
      wb_sel_wb_d   = WB_sel_MEM;
      misalign_wb_d = valid_MEM & ~flush_MEM & is_mem & misaligned;
      // Only a load completing out of WAIT_RESP carries response data.
      dout_wb_d     = (state_q == WAIT_RESP && !flush_MEM) ? dcache_resp_data : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      valid_wb_q    <= 1'b0;
      inst_wb_q     <= INST_W'(32'h0000_0013);
      pc_wb_q       <= '0;
      alu_wb_q      <= '0;
      wb_sel_wb_q   <= 2'b00;
      dout_wb_q     <= '0;
      misalign_wb_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_wb_q    <= valid_wb_d;
      inst_wb_q     <= inst_wb_d;
      pc_wb_q       <= pc_wb_d;
      alu_wb_q      <= alu_wb_d;
      wb_sel_wb_q   <= wb_sel_wb_d;
      dout_wb_q     <= dout_wb_d;
      misalign_wb_q <= misalign_wb_d;
    end
  end

  assign valid_WB       = valid_wb_q;
  assign inst_WB        = inst_wb_q;
  assign pc_WB          = pc_wb_q;
  assign ALU_WB         = alu_wb_q;
  assign WB_sel_WB      = wb_sel_wb_q;
  assign dcache_dout_WB = dout_wb_q;
  assign misalign_WB    = misalign_wb_q;
  assign state_dbg      = state_q;

endmodule
